// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch/JR hazard sequencer: stalls for in-flight operands, then steers MEM forwarding and PC redirect.
// Optional BRCTL_DELAY_SLOT_EN: branch delay slot, the IF/ID instruction is never squashed.
module branch_hazard_ctrl #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_jr,
  input  logic             id_jump,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             taken,
  output logic             stall,
  output logic             id_ex_bubble,
  output logic             if_flush,
  output logic             pc_redirect,
  output logic             fwd_a,
  output logic             fwd_b
);

  typedef enum logic [1:0] {IDLE, HOLD, RESOLVE} state_t;

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [1:0] need;
  logic       ctl;
  logic       rs_live, rt_live;
  logic       ex_hit, mem_ld_hit;
  logic       stall_c, resolve_c;

  // Register 0 is hardwired, so it never creates a dependency or a forward.
  assign rs_live    = (id_rs != '0);
  assign rt_live    = id_uses_rt & (id_rt != '0);
  assign ctl        = id_valid & (id_branch | id_jr);

  assign ex_hit     = ex_regwrite & ((rs_live & (ex_rd == id_rs)) |
                                     (rt_live & (ex_rd == id_rt)));
  assign mem_ld_hit = mem_memread & ((rs_live & (mem_rd == id_rs)) |
                                     (rt_live & (mem_rd == id_rt)));

  always_comb begin
    if (ex_hit & ex_memread)                     need = 2'd2;
    else if ((ex_hit & ~ex_memread) | mem_ld_hit) need = 2'd1;
    else                                         need = 2'd0;
  end

  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    resolve_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctl) begin
          if (need == 2'd0) begin
            resolve_c = 1'b1;
          end else begin
            cnt_nxt   = need;
            state_nxt = HOLD;
          end
        end else if (id_valid & id_jump) begin
          resolve_c = 1'b1;
        end
      end
      HOLD: begin
        if (!id_valid) begin
          cnt_nxt   = 2'd0;
          state_nxt = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_nxt = cnt - 2'd1;
          if (cnt <= 2'd1) state_nxt = RESOLVE;
        end
      end
      RESOLVE: begin
        resolve_c = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = 2'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Reset masks everything so an aborted hold never leaks a stall or redirect.
  assign stall        = ~reset & stall_c;
  assign id_ex_bubble = ~reset & stall_c;
  assign pc_redirect  = ~reset & resolve_c & (taken | id_jump);
  assign fwd_a        = ~reset & resolve_c & mem_regwrite & ~mem_memread &
                        rs_live & (mem_rd == id_rs);
  assign fwd_b        = ~reset & resolve_c & mem_regwrite & ~mem_memread &
                        rt_live & (mem_rd == id_rt);

`ifdef BRCTL_DELAY_SLOT_EN
  assign if_flush = 1'b0;
`else
  assign if_flush = pc_redirect;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl; expected output vectors are hand-derived per scenario.
module tb_branch_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_branch, id_jr, id_jump, id_uses_rt;
  logic [4:0] id_rs, id_rt;
  logic       ex_regwrite, ex_memread;
  logic [4:0] ex_rd;
  logic       mem_regwrite, mem_memread;
  logic [4:0] mem_rd;
  logic       taken;
  logic       stall, id_ex_bubble, if_flush, pc_redirect, fwd_a, fwd_b;

  int n_vec = 0;
  int n_mis = 0;

`ifdef BRCTL_DELAY_SLOT_EN
  localparam logic FL = 1'b0;
`else
  localparam logic FL = 1'b1;
`endif

  // {stall, id_ex_bubble, if_flush, pc_redirect, fwd_a, fwd_b}
  localparam logic [5:0] ZERO   = 6'b000000;
  localparam logic [5:0] HOLDV  = 6'b110000;
  localparam logic [5:0] REDIR  = {2'b00, FL, 3'b100};

  branch_hazard_ctrl #(.REG_W(5)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_branch(id_branch), .id_jr(id_jr), .id_jump(id_jump),
    .id_uses_rt(id_uses_rt), .id_rs(id_rs), .id_rt(id_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .taken(taken),
    .stall(stall), .id_ex_bubble(id_ex_bubble), .if_flush(if_flush),
    .pc_redirect(pc_redirect), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {stall, id_ex_bubble, if_flush, pc_redirect, fwd_a, fwd_b};
  endfunction

  // Inputs change 1 time unit after the rising edge and are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic br, input logic jr, input logic j,
                        input logic urt, input logic [4:0] rs, input logic [4:0] rt,
                        input logic tk);
    id_valid = v; id_branch = br; id_jr = jr; id_jump = j;
    id_uses_rt = urt; id_rs = rs; id_rt = rt; taken = tk;
  endtask

  task automatic set_ex(input logic rw, input logic mr, input logic [4:0] rd);
    ex_regwrite = rw; ex_memread = mr; ex_rd = rd;
  endtask

  task automatic set_mem(input logic rw, input logic mr, input logic [4:0] rd);
    mem_regwrite = rw; mem_memread = mr; mem_rd = rd;
  endtask

  task automatic clear_all();
    set_id(0, 0, 0, 0, 0, 5'd0, 5'd0, 0);
    set_ex(0, 0, 5'd0);
    set_mem(0, 0, 5'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_all();
    step(); step();
    #1;
    n_vec++;
    if (outs() !== ZERO) begin n_mis++; $display("FAIL reset_active: got %b expected %b", outs(), ZERO); end
    step();
    reset = 1'b0;
    #1;
    n_vec++;
    if (outs() !== ZERO) begin n_mis++; $display("FAIL reset_release: got %b expected %b", outs(), ZERO); end
    step();
  endtask

  task automatic test_reset_mid_hold();
    set_id(1, 1, 0, 0, 1, 5'd3, 5'd4, 1);
    set_ex(1, 1, 5'd3);
    #1;
    n_vec++;
    if (outs() !== ZERO) begin n_mis++; $display("FAIL rst_hold_detect: got %b expected %b", outs(), ZERO); end
    step();
    n_vec++;
    if (outs() !== HOLDV) begin n_mis++; $display("FAIL rst_hold_enter: got %b expected %b", outs(), HOLDV); end
    reset = 1'b1;
    #1;
    n_vec++;
    if (outs() !== ZERO) begin n_mis++; $display("FAIL rst_hold_during: got %b expected %b", outs(), ZERO); end
    step();
    reset = 1'b0;
    // Back in IDLE: a hazard-free taken branch must redirect immediately rather than stall.
    set_ex(0, 0, 5'd0);
    #1;
    n_vec++;
    if (outs() !== REDIR) begin n_mis++; $display("FAIL rst_hold_idle: got %b expected %b", outs(), REDIR); end
    clear_all();
    step();
  endtask

  task automatic test_ex_load();
    set_id(1, 1, 0, 0, 1, 5'd3, 5'd4, 1);
    set_ex(1, 1, 5'd3);
    #1;
    n_vec++;
    if (outs() !== ZERO) begin n_mis++; $display("FAIL exld_detect: got %b expected %b", outs(), ZERO); end
    step();
    n_vec++;
    if (outs() !== HOLDV) begin n_mis++; $display("FAIL exld_hold1: got %b expected %b", outs(), HOLDV); end
    step();
    n_vec++;
    if (outs() !== HOLDV) begin n_mis++; $display("FAIL exld_hold2: got %b expected %b", outs(), HOLDV); end
    step();
    set_ex(0, 0, 5'd0);
    set_mem(1, 1, 5'd3);
    #1;
    n_vec++;
    if (outs() !== REDIR) begin n_mis++; $display("FAIL exld_resolve: got %b expected %b", outs(), REDIR); end
    clear_all();
    step();
    n_vec++;
    if (outs() !== ZERO) begin n_mis++; $display("FAIL exld_after: got %b expected %b", outs(), ZERO); end
  endtask

  task automatic test_ex_alu();
    set_id(1, 1, 0, 0, 1, 5'd5, 5'd6, 0);
    set_ex(1, 0, 5'd5);
    #1;
    n_vec++;
    if (outs() !== ZERO) begin n_mis++; $display("FAIL exalu_detect: got %b expected %b", outs(), ZERO); end
    step();
    n_vec++;
    if (outs() !== HOLDV) begin n_mis++; $display("FAIL exalu_hold: got %b expected %b", outs(), HOLDV); end
    step();
    set_ex(0, 0, 5'd0);
    set_mem(1, 0, 5'd5);
    #1;
    n_vec++;
    if (outs() !== 6'b000010) begin n_mis++; $display("FAIL exalu_resolve: got %b expected %b", outs(), 6'b000010); end
    clear_all();
    step();
  endtask

  task automatic test_zero_reg();
    set_id(1, 1, 0, 0, 0, 5'd0, 5'd0, 1);
    set_ex(1, 1, 5'd0);
    set_mem(1, 0, 5'd0);
    #1;
    n_vec++;
    if (outs() !== REDIR) begin n_mis++; $display("FAIL zero_reg: got %b expected %b", outs(), REDIR); end
    clear_all();
    step();
    n_vec++;
    if (outs() !== ZERO) begin n_mis++; $display("FAIL zero_reg_after: got %b expected %b", outs(), ZERO); end
  endtask

  task automatic test_jump();
    // J whose rs field aliases a pending load: jumps need no operands, so no stall.
    set_id(1, 0, 0, 1, 0, 5'd3, 5'd0, 0);
    set_ex(1, 1, 5'd3);
    #1;
    n_vec++;
    if (outs() !== REDIR) begin n_mis++; $display("FAIL jump: got %b expected %b", outs(), REDIR); end
    step();
    // Still IDLE: hazard-free not-taken BEQ with an rt forward from MEM.
    set_id(1, 1, 0, 0, 1, 5'd8, 5'd9, 0);
    set_ex(0, 0, 5'd0);
    set_mem(1, 0, 5'd9);
    #1;
    n_vec++;
    if (outs() !== 6'b000001) begin n_mis++; $display("FAIL jump_next_fwdb: got %b expected %b", outs(), 6'b000001); end
    clear_all();
    step();
    set_id(1, 0, 1, 0, 0, 5'd7, 5'd0, 1);
    set_mem(1, 1, 5'd7);
    #1;
    n_vec++;
    if (outs() !== ZERO) begin n_mis++; $display("FAIL jr_detect: got %b expected %b", outs(), ZERO); end
    step();
    n_vec++;
    if (outs() !== HOLDV) begin n_mis++; $display("FAIL jr_hold: got %b expected %b", outs(), HOLDV); end
    step();
    set_mem(0, 0, 5'd0);
    #1;
    n_vec++;
    if (outs() !== REDIR) begin n_mis++; $display("FAIL jr_resolve: got %b expected %b", outs(), REDIR); end
    clear_all();
    step();
  endtask

  task automatic test_flush_in_hold();
    set_id(1, 1, 0, 0, 1, 5'd3, 5'd4, 1);
    set_ex(1, 1, 5'd4);
    #1;
    step();
    n_vec++;
    if (outs() !== HOLDV) begin n_mis++; $display("FAIL flush_hold: got %b expected %b", outs(), HOLDV); end
    id_valid = 1'b0;
    #1;
    n_vec++;
    if (outs() !== ZERO) begin n_mis++; $display("FAIL flush_drop: got %b expected %b", outs(), ZERO); end
    step();
    set_id(1, 1, 0, 0, 1, 5'd8, 5'd9, 1);
    set_ex(0, 0, 5'd0);
    #1;
    n_vec++;
    if (outs() !== REDIR) begin n_mis++; $display("FAIL flush_next_branch: got %b expected %b", outs(), REDIR); end
    clear_all();
    step();
  endtask

  initial begin
    test_reset();
    test_reset_mid_hold();
    test_ex_load();
    test_ex_alu();
    test_zero_reg();
    test_jump();
    test_flush_in_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
